serial_tx: RTL and testbench
============================

# serial_tx

Parallel-to-serial frame transmitter. Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out on a single-bit line as an asynchronous-style frame: start bit, LSB-first data bits, optional even parity bit, stop bit, with DIV clocks per bit. It is the transmit end of the single-bit `di` serial input path: its `do` output drives that path's `di` input, in the same clock domain.

## Interface
- WIDTH, 8: data bits per frame; ≥1.
- DIV, 4: clock cycles per serial bit; ≥1. Counter width is max(1, clog2(DIV)).
- PARITY, 0: 0 = no parity bit; 1 = even parity bit inserted after the data bits.

- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  WIDTH  word to transmit; sampled only on accept.
- din_valid  in  1  the word on `din` is valid.
- din_ready  out  1  the block can accept a word.
- do  out  1  serial line; idle high; registered.
- busy  out  1  high from the accept edge until the last stop-bit cycle completes.

## Operation
- States: IDLE, START, DATA, PAR, STOP.
- IDLE: `do`=1, `busy`=0. `din_ready`=1 when `rst`=0, and 0 while `rst`=1.
- Accept happens on an edge where `din_valid`=1, `din_ready`=1 and `rst`=0. On that edge:
  - `din` loads into the shift register.
  - The parity bit is latched as the XOR of all bits of `din`.
  - `div_cnt` and `bit_cnt` clear.
  - State goes to START.
- `div_cnt` counts 0..DIV-1 in every non-IDLE state. A bit ends on the edge where `div_cnt`=DIV-1.
- State transitions at bit end:
  - START → DATA.
  - DATA → DATA while `bit_cnt` < WIDTH-1; the shift register shifts right and `bit_cnt` increments.
  - DATA → PAR when `bit_cnt`=WIDTH-1 and PARITY=1; DATA → STOP when `bit_cnt`=WIDTH-1 and PARITY=0.
  - PAR → STOP.
  - STOP → IDLE.
- `do` value per state: START=0; DATA=shift register bit 0; PAR=latched parity; STOP=1.
- `din_valid` high while not in IDLE is ignored; `din` may change freely and the frame in flight is unaffected.
- Reset, including mid-frame: the next edge forces IDLE, `do`=1, `busy`=0, and clears both counters. A partial frame is truncated with no stop bit. `din_ready`=0 for the whole time `rst` is high.
- Reset values: `do`=1, `busy`=0, `din_ready`=0 while in reset, 1 on the first cycle after `rst` falls.

## Timing
- Accept edge t0: `do`=0 and `busy`=1 from t0 for DIV cycles (START).
- Data bit i (0-based) drives `do` over [t0+(1+i)·DIV, t0+(2+i)·DIV).
- Frame length F = (WIDTH+2+PARITY)·DIV cycles. The STOP bit occupies the final DIV cycles.
- On edge t0+F: state = IDLE and `din_ready`=1 combinationally in that cycle. If `din_valid` is high, the next accept happens on edge t0+F+1.
- Back-to-back minimum period is F+1 cycles: one idle-high cycle between frames.
- DIV=1: each bit lasts exactly one cycle; the counter never advances past 0.
- Accept-to-first-line-transition latency: 0 cycles after the accept edge, because `do` is registered on that edge.

## Test plan
- Reset: hold `rst` for 3 cycles with `din_valid`=1 → `do`=1, `busy`=0, `din_ready`=0, no accept. On the first cycle after release, `din_ready`=1.
- Single frame, WIDTH=8, DIV=4, PARITY=0, `din`=0xA5 → `do` = 0, 1,0,1,0,0,1,0,1, 1, each held 4 cycles (40 cycles total). `busy` is high for exactly 40 cycles, then `din_ready`=1.
- Parity, PARITY=1, DIV=4, `din`=0x07 → parity bit 1 after the data. With `din`=0x03 → parity bit 0. Frame length is 44 cycles.
- Back-to-back: `din_valid` held high with 0x00 then 0xFF → second start bit begins exactly F+1 cycles after the first accept. One idle-high cycle separates the frames.
- Ignored input: change `din` and pulse `din_valid` mid-frame → transmitted bits unchanged and no extra frame is sent.
- Mid-frame reset: assert `rst` during data bit 3 of 0x5A → `do`=1 and `busy`=0 from the next edge. After release, a new 0x3C frame is sent intact.

Source files
------------

// File: rtl/serial_tx_if.sv
// Word handshake into the serial transmitter: the producer drives din/din_valid,
// the transmitter answers with din_ready.
interface serial_tx_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;

  modport master (
    output din,
    output din_valid,
    input  din_ready
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready
  );
endinterface

// File: rtl/serial_tx.sv
// Parallel-to-serial frame transmitter: start bit, LSB-first data, optional even
// parity, stop bit, each bit held for DIV clocks. Line idles high.
module serial_tx #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIV    = 4,
  parameter int unsigned PARITY = 0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  serial_tx_if.slave   in_if,
  output logic         do_o,
  output logic         busy_o
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BitW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] DivLast = CntW'(DIV - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shift_q;
  logic             par_q;
  logic [CntW-1:0]  div_cnt_q;
  logic [BitW-1:0]  bit_cnt_q;
  logic             do_q;
  logic             busy_q;

  logic             accept;
  logic             bit_end;
  logic [WIDTH-1:0] shift_nxt;

  // Ready is combinational so a new word can be taken the cycle after STOP ends.
  assign in_if.din_ready = (state_q == StIdle) && !rst_i;
  assign accept          = in_if.din_valid && in_if.din_ready;
  assign bit_end         = (div_cnt_q == DivLast);
  assign do_o            = do_q;
  assign busy_o          = busy_q;

  // Shifted word, so the next data bit can be registered onto the line at bit end.
  always_comb begin
    shift_nxt = shift_q >> 1;
  end

  // Frame FSM; the line and busy are registered alongside the state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      par_q     <= 1'b0;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      do_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      if (state_q != StIdle) begin
        div_cnt_q <= bit_end ? '0 : div_cnt_q + 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            shift_q   <= in_if.din;
            par_q     <= ^in_if.din;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            do_q      <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= StStart;
          end
        end
        StStart: begin
          if (bit_end) begin
            do_q    <= shift_q[0];
            state_q <= StData;
          end
        end
        StData: begin
          if (bit_end) begin
            if (bit_cnt_q != BitLast) begin
              shift_q   <= shift_nxt;
              bit_cnt_q <= bit_cnt_q + 1'b1;
              do_q      <= shift_nxt[0];
            end else if (PARITY != 0) begin
              do_q    <= par_q;
              state_q <= StPar;
            end else begin
              do_q    <= 1'b1;
              state_q <= StStop;
            end
          end
        end
        StPar: begin
          if (bit_end) begin
            do_q    <= 1'b1;
            state_q <= StStop;
          end
        end
        StStop: begin
          if (bit_end) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          do_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: three configurations (DIV=4 no parity, DIV=4 parity, DIV=1
// parity). Every accepted word pushes its expected per-cycle line values into a
// queue; a monitor pops one value per clock and checks line, busy and ready.
module tb_serial_tx;
  localparam int unsigned W = 8;

  typedef struct {
    int         sel;
    logic [7:0] data;
    bit         glitch;
    logic [7:0] gdata;
    int         exp_len;
    logic       exp_par;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [W-1:0] din;
  logic         valid0, valid1, valid2;
  logic         do0, do1, do2, busy0, busy1, busy2;
  logic [1:0]   sel;
  logic         do_s, busy_s, rdy_s, valid_s;

  serial_tx_if #(.WIDTH(W)) bus0 ();
  serial_tx_if #(.WIDTH(W)) bus1 ();
  serial_tx_if #(.WIDTH(W)) bus2 ();

  assign bus0.din = din;
  assign bus1.din = din;
  assign bus2.din = din;
  assign bus0.din_valid = valid0;
  assign bus1.din_valid = valid1;
  assign bus2.din_valid = valid2;

  serial_tx #(.WIDTH(W), .DIV(4), .PARITY(0)) u0 (
    .clk_i(clk), .rst_i(rst), .in_if(bus0), .do_o(do0), .busy_o(busy0));
  serial_tx #(.WIDTH(W), .DIV(4), .PARITY(1)) u1 (
    .clk_i(clk), .rst_i(rst), .in_if(bus1), .do_o(do1), .busy_o(busy1));
  serial_tx #(.WIDTH(W), .DIV(1), .PARITY(1)) u2 (
    .clk_i(clk), .rst_i(rst), .in_if(bus2), .do_o(do2), .busy_o(busy2));

  always_comb begin
    do_s = do0; busy_s = busy0; rdy_s = bus0.din_ready; valid_s = valid0;
    case (sel)
      2'd1: begin do_s = do1; busy_s = busy1; rdy_s = bus1.din_ready; valid_s = valid1; end
      2'd2: begin do_s = do2; busy_s = busy2; rdy_s = bus2.din_ready; valid_s = valid2; end
      default: ;
    endcase
  end

  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  logic exp_q[$];
  int   acc_times[$];
  int   busy_run = 0;
  int   last_busy_len = 0;

  function automatic int div_of(input logic [1:0] s);
    return (s == 2'd2) ? 1 : 4;
  endfunction

  function automatic bit par_of(input logic [1:0] s);
    return (s != 2'd0);
  endfunction

  function automatic void check(input string name, input logic [31:0] got,
                                input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, got, exp);
    end
  endfunction

  // Expected line, one entry per clock: start, data LSB first, parity, stop.
  function automatic void push_frame(input logic [W-1:0] d);
    int dv;
    dv = div_of(sel);
    for (int r = 0; r < dv; r++) exp_q.push_back(1'b0);
    for (int i = 0; i < int'(W); i++)
      for (int r = 0; r < dv; r++) exp_q.push_back(d[i]);
    if (par_of(sel))
      for (int r = 0; r < dv; r++) exp_q.push_back(^d);
    for (int r = 0; r < dv; r++) exp_q.push_back(1'b1);
  endfunction

  // Accept observer: pre-edge values decide whether this edge accepts a word.
  initial forever begin
    @(posedge clk);
    if (!rst && valid_s && rdy_s) begin
      push_frame(din);
      acc_times.push_back(cyc);
    end
    cyc++;
  end

  // Per-cycle monitor.
  initial forever begin
    logic e_do, e_busy, e_rdy;
    @(posedge clk);
    #1;
    if (mon_en) begin
      e_busy = (exp_q.size() != 0);
      e_do   = e_busy ? exp_q.pop_front() : 1'b1;
      e_rdy  = !e_busy && !rst;
      check("line/busy/ready", {29'd0, rdy_s, busy_s, do_s}, {29'd0, e_rdy, e_busy, e_do});
      if (busy_s) busy_run++;
      else if (busy_run != 0) begin
        last_busy_len = busy_run;
        busy_run = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic set_valid(input bit v);
    valid0 = v && (sel == 2'd0);
    valid1 = v && (sel == 2'd1);
    valid2 = v && (sel == 2'd2);
  endtask

  task automatic wait_accept(input int n0, input int limit);
    for (int i = 0; i < limit && acc_times.size() <= n0; i++) @(negedge clk);
    check("accept_seen", acc_times.size() > n0, 1);
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit && (exp_q.size() != 0 || busy_s); i++) @(negedge clk);
    check("frame_done", busy_s, 0);
    check("ready_after_frame", rdy_s, 1);
  endtask

  task automatic send_check(input vec_t v);
    int n0;
    sel = v.sel[1:0];
    @(negedge clk);
    n0 = acc_times.size();
    din = v.data;
    set_valid(1'b1);
    wait_accept(n0, 20);
    set_valid(1'b0);
    if (v.glitch) begin
      repeat (10) @(negedge clk);
      din = v.gdata;
      set_valid(1'b1);
      @(negedge clk);
      set_valid(1'b0);
      din = ~v.gdata;
    end else if (par_of(sel)) begin
      repeat ((1 + W) * div_of(sel)) @(negedge clk);
      check("parity_bit", do_s, v.exp_par);
    end
    wait_idle(200);
    check("busy_length", last_busy_len, v.exp_len);
    repeat (3) @(negedge clk);
    check("no_extra_frame", acc_times.size(), n0 + 1);
  endtask

  initial begin
    vec_t vecs[7];
    int   n0;
    vecs[0] = '{0, 8'hA5, 1'b0, 8'h00, 40, 1'b0};
    vecs[1] = '{1, 8'h07, 1'b0, 8'h00, 44, 1'b1};
    vecs[2] = '{1, 8'h03, 1'b0, 8'h00, 44, 1'b0};
    vecs[3] = '{0, 8'h3C, 1'b1, 8'hFF, 40, 1'b0};
    vecs[4] = '{2, 8'hB4, 1'b0, 8'h00, 11, 1'b0};
    vecs[5] = '{2, 8'h01, 1'b0, 8'h00, 11, 1'b1};
    vecs[6] = '{1, 8'hFF, 1'b0, 8'h00, 44, 1'b0};

    // Reset held 3 cycles with valid high: nothing accepted.
    sel = 2'd0; rst = 1'b1; din = 8'h55;
    valid0 = 1'b1; valid1 = 1'b0; valid2 = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    check("ready_in_reset", rdy_s, 0);
    check("no_accept_in_reset", acc_times.size(), 0);
    valid0 = 1'b0;
    rst = 1'b0;
    #1;
    check("ready_after_release", rdy_s, 1);
    @(negedge clk);

    for (int i = 0; i < 7; i++) send_check(vecs[i]);

    // Back-to-back with valid held: second accept exactly F+1 cycles later.
    sel = 2'd0;
    @(negedge clk);
    n0 = acc_times.size();
    din = 8'h00;
    set_valid(1'b1);
    wait_accept(n0, 20);
    din = 8'hFF;
    wait_accept(n0 + 1, 80);
    set_valid(1'b0);
    if (acc_times.size() >= n0 + 2)
      check("b2b_period", acc_times[n0 + 1] - acc_times[n0], 41);
    wait_idle(100);

    // Reset during data bit 3 of 0x5A, then a clean 0x3C frame.
    @(negedge clk);
    n0 = acc_times.size();
    din = 8'h5A;
    set_valid(1'b1);
    wait_accept(n0, 20);
    set_valid(1'b0);
    repeat (17) @(negedge clk);
    check("bit3_before_reset", do_s, 1);
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("busy_low_in_reset", busy_s, 0);
    check("line_high_in_reset", do_s, 1);
    rst = 1'b0;
    send_check('{0, 8'h3C, 1'b0, 8'h00, 40, 1'b0});

    repeat (5) @(negedge clk);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
